// File: rtl/delay_sequencer_pkg.sv
// Shared types for the delay sequencer: FSM state encoding and the queued request word.
// The request word layout is {tag, count} so a FIFO entry carries everything needed to start a run.
package delay_sequencer_pkg;

    localparam int SEQ_COUNT_W = 4;
    localparam int SEQ_TAG_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [SEQ_TAG_W-1:0]   tag;
        logic [SEQ_COUNT_W-1:0] count;
    } req_t;

endpackage

// File: rtl/delay_sequencer_fifo.sv
// Request buffer for the delay sequencer: DEPTH-entry synchronous FIFO with a flush input.
// The head entry is presented combinationally so the controller can pop and use it in one cycle.
module seq_fifo
    import delay_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   occ_r;
    logic          push_s;
    logic          pop_s;

    // Occupancy needs one extra bit so a full FIFO is distinguishable from an empty one.
    assign full     = (occ_r == (AW+1)'(DEPTH));
    assign empty    = (occ_r == (AW+1)'(0));
    assign push_s   = push && !full && !flush;
    assign pop_s    = pop && !empty && !flush;
    assign pop_data = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            occ_r    <= (AW+1)'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            occ_r    <= (AW+1)'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + (AW+1)'(1);
                2'b01:   occ_r <= occ_r - (AW+1)'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/delay_sequencer.sv
// Delay sequencer: queues {count, tag} requests, drives an external down-counter through
// latch/dec/zero, and emits a one-cycle tagged completion pulse when the counter reaches zero.
module delay_sequencer
    import delay_sequencer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int COUNT_W  = SEQ_COUNT_W,
    parameter int TAG_W    = SEQ_TAG_W,
    parameter int PRESCALE = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               abort,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COUNT_W-1:0] req_count,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               cnt_latch,
    output logic [COUNT_W-1:0] cnt_in,
    output logic               cnt_dec,
    input  logic               cnt_zero,
    output logic               done_valid,
    output logic [TAG_W-1:0]   done_tag,
    output logic               busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t             state_r;
    state_t             state_s;
    logic [PW-1:0]      presc_r;
    logic [PW-1:0]      presc_s;
    logic [TAG_W-1:0]   cur_tag_r;
    logic [TAG_W-1:0]   cur_tag_s;
    logic [COUNT_W-1:0] cnt_in_r;
    logic [COUNT_W-1:0] cnt_in_s;
    logic               cnt_latch_r;
    logic               cnt_latch_s;
    logic               done_valid_r;
    logic               done_valid_s;
    logic [TAG_W-1:0]   done_tag_r;
    logic [TAG_W-1:0]   done_tag_s;
    logic               pop_s;
    logic               tick_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    req_t               push_data_s;
    req_t               head_s;

    assign push_data_s.tag   = req_tag;
    assign push_data_s.count = req_count;

    seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (abort),
        .push      (req_valid && req_ready),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign req_ready = !fifo_full_s && !abort;
    assign tick_s    = (presc_r == PW'(PRESCALE - 1));
    // Combinational so a decrement is suppressed in the very cycle the counter reports zero.
    assign cnt_dec   = (state_r == RUN) && tick_s && !cnt_zero;

    assign cnt_latch  = cnt_latch_r;
    assign cnt_in     = cnt_in_r;
    assign done_valid = done_valid_r;
    assign done_tag   = done_tag_r;
    assign busy       = (state_r != IDLE) || !fifo_empty_s;

    // Next-state and registered-output decode; abort overrides every state.
    always_comb begin
        state_s      = state_r;
        presc_s      = presc_r;
        cur_tag_s    = cur_tag_r;
        cnt_in_s     = cnt_in_r;
        cnt_latch_s  = 1'b0;
        done_valid_s = 1'b0;
        done_tag_s   = done_tag_r;
        pop_s        = 1'b0;
        if (abort) begin
            state_s = IDLE;
            presc_s = PW'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        cnt_in_s    = head_s.count;
                        cur_tag_s   = head_s.tag;
                        cnt_latch_s = 1'b1;
                        state_s     = LOAD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD: begin
                    presc_s = PW'(0);
                    state_s = RUN;
                end
                RUN: begin
                    // cnt_zero is only trusted here: the counter is loaded before RUN is entered.
                    if (cnt_zero) begin
                        done_valid_s = 1'b1;
                        done_tag_s   = cur_tag_r;
                        state_s      = DONE;
                    end else begin
                        presc_s = tick_s ? PW'(0) : presc_r + PW'(1);
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, prescaler and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            presc_r      <= PW'(0);
            cur_tag_r    <= TAG_W'(0);
            cnt_in_r     <= COUNT_W'(0);
            cnt_latch_r  <= 1'b0;
            done_valid_r <= 1'b0;
            done_tag_r   <= TAG_W'(0);
        end else begin
            state_r      <= state_s;
            presc_r      <= presc_s;
            cur_tag_r    <= cur_tag_s;
            cnt_in_r     <= cnt_in_s;
            cnt_latch_r  <= cnt_latch_s;
            done_valid_r <= done_valid_s;
            done_tag_r   <= done_tag_s;
        end
    end

endmodule

// File: doc/delay_sequencer.md
Name: delay_sequencer

Overview:
Command-side controller that sits directly upstream of the 4-bit down-counter (latch/dec/zero interface).
- Accepts delay requests {count, tag} over a valid/ready handshake and buffers them in a small FIFO.
- Loads each count into the counter, paces decrements with a prescaler, and watches the counter's zero flag.
- Emits a one-cycle completion pulse carrying the request tag.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
COUNT_W, 4, count width; must equal the counter's input width
TAG_W, 2, request tag width
PRESCALE, 1, RUN cycles per decrement (>=1); 1 = decrement every cycle

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
abort  in  1  synchronous flush of FIFO and current operation
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready at clock edge
req_count  in  COUNT_W  delay length N
req_tag  in  TAG_W  request identifier
cnt_latch  out  1  to counter latch
cnt_in  out  COUNT_W  to counter in
cnt_dec  out  1  to counter dec
cnt_zero  in  1  from counter zero
done_valid  out  1  one-cycle completion pulse
done_tag  out  TAG_W  tag of completed request, valid with done_valid
busy  out  1  high when state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, active-high):
  - FIFO empty, state IDLE, prescale count 0.
  - cnt_latch, cnt_dec, done_valid and busy are 0; cnt_in and done_tag are 0.
  - req_ready is 1 once reset deasserts.
- Counter interaction:
  - The counter has no reset, so cnt_zero is ignored in every state except RUN.
- FIFO:
  - req_ready = !full && !abort.
  - A push and a pop in the same cycle are legal.
  - A push into an empty FIFO becomes poppable on the next cycle.
  - Pointers wrap modulo DEPTH.
  - An occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- FSM, states IDLE, LOAD, RUN, DONE; all outputs registered except cnt_dec:
  - IDLE: if FIFO non-empty, pop the head; register cnt_in <= head count, cur_tag <= head tag, cnt_latch <= 1; go to LOAD. Otherwise stay in IDLE.
  - LOAD: cnt_latch is high for exactly this cycle, so the counter loads at the end of it. Clear cnt_latch, clear the prescaler, go to RUN.
  - RUN: tick = (prescale count == PRESCALE-1); the prescaler wraps to 0 on tick.
    - cnt_dec = (state==RUN) && tick && !cnt_zero. This is combinational, so a decrement is never issued at zero.
    - If cnt_zero: register done_valid <= 1, done_tag <= cur_tag, go to DONE.
  - DONE: done_valid is high for this single cycle; go to IDLE.
  - The next request is popped no earlier than the IDLE cycle that follows DONE.
- Latency:
  - The accept edge is E0. done_valid is high in the cycle after edge E0 + P*N + 3 (P = PRESCALE).
  - With P=1: N=5 gives done 8 cycles after acceptance; N=0 gives done 3 cycles after acceptance (RUN exits immediately, no cnt_dec).
  - Back-to-back requests are spaced P*N + 4 cycles apart in steady state.
- abort (sync, priority below reset, above everything else):
  - Next edge: FIFO empty, state IDLE, cnt_latch=0, done_valid=0.
  - The in-flight request is dropped with no done pulse.
  - The counter keeps its value; this is harmless because it is reloaded before the next RUN.
  - A request presented during abort is not accepted.
- Overflow: a count of 2^COUNT_W-1 is legal and needs no special handling. No arithmetic wraps inside this block.

Decomposition:
- Shared package holds:
  - state enum {IDLE, LOAD, RUN, DONE}, 2-bit encoding 0..3;
  - COUNT_W = 4, matching the counter;
  - typedef req_t = {tag, count} packed, used as the FIFO data word.
- Sub-module seq_fifo: synchronous DEPTH-entry FIFO with push/pop/full/empty, async active-high reset, and a flush input driven by abort.
- The FSM and prescaler live in delay_sequencer.

Test Plan:
- Single request, N=5, tag=2, P=1 -> cnt_latch high one cycle with cnt_in=5; exactly 5 cnt_dec cycles; done_valid with done_tag=2 in cycle E0+8.
- N=0, tag=1 -> no cnt_dec asserted; done_valid with done_tag=1 at E0+3.
- Fill: push 5 requests back-to-back with DEPTH=4 and a long first count:
  - req_ready drops after 4 entries are held;
  - the 5th is accepted once the first pop frees space;
  - done tags appear in order 0,1,2,3,0.
- PRESCALE=3, N=2 -> cnt_dec pulses 3 cycles apart; done at E0+9.
- Abort mid-RUN with 2 requests queued -> no done_valid for any of them, busy=0 next cycle, and req_ready is low during the abort cycle. A new request afterwards completes normally.
- Async reset asserted mid-RUN, between edges -> all outputs 0 immediately and FIFO empty; a post-reset request with N=3 completes at E0+6.
